// File: rtl/hdmi_btn_pkg.sv
// Shared types for the front-panel button event controller.
package hdmi_btn_pkg;

    // Event codes as seen by the configuration register block.
    typedef enum logic [1:0] {
        EvtPress   = 2'd0,
        EvtLong    = 2'd1,
        EvtRepeat  = 2'd2,
        EvtRelease = 2'd3
    } evt_type_t;

    // Per-button press tracking.
    typedef enum logic [1:0] {
        StIdle     = 2'd0,
        StWaitLong = 2'd1,
        StHeld     = 2'd2
    } btn_state_t;

endpackage

// File: rtl/btn_evt_fsm.sv
// One button: edge detect, tick counter, press/long/repeat FSM and a single pending-event slot.
module btn_evt_fsm
    import hdmi_btn_pkg::*;
#(
    parameter int unsigned LONG_TICKS   = 500,
    parameter int unsigned REPEAT_TICKS = 100
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_btn,
    input  logic       i_tick,
    input  logic       i_grant,
    output logic       o_pend_valid,
    output logic [1:0] o_pend_type,
    output logic       o_drop
);
    localparam int unsigned MaxTicks = (LONG_TICKS > REPEAT_TICKS) ? LONG_TICKS : REPEAT_TICKS;
    localparam int unsigned CntW     = $clog2(MaxTicks + 1);

    logic            btn_q;
    logic            rise;
    logic            fall;
    btn_state_t      state_q;
    btn_state_t      state_d;
    logic [CntW-1:0] cnt_q;
    logic [CntW-1:0] cnt_d;
    logic [CntW:0]   cnt_inc;
    logic            long_hit;
    logic            rep_hit;
    logic            post;
    evt_type_t       post_type;
    logic            pend_valid_q;
    evt_type_t       pend_type_q;
    logic            drop_q;

    assign rise     = i_btn & ~btn_q;
    assign fall     = ~i_btn & btn_q;
    assign cnt_inc  = {1'b0, cnt_q} + (CntW+1)'(1);
    assign long_hit = i_tick && (cnt_inc == (CntW+1)'(LONG_TICKS));
    assign rep_hit  = i_tick && (REPEAT_TICKS != 0) && (cnt_inc == (CntW+1)'(REPEAT_TICKS));

    // State register, tick counter and the delayed button level used for edge detection.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            btn_q   <= 1'b0;
            state_q <= StIdle;
            cnt_q   <= '0;
        end else begin
            btn_q   <= i_btn;
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next state and counter; a release always wins over a same-cycle tick expiry.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            StIdle: begin
                if (rise) begin
                    state_d = StWaitLong;
                    cnt_d   = '0;
                end
            end
            StWaitLong: begin
                if (fall) begin
                    state_d = StIdle;
                end else if (long_hit) begin
                    state_d = StHeld;
                    cnt_d   = '0;
                end else if (i_tick) begin
                    cnt_d = cnt_inc[CntW-1:0];
                end
            end
            StHeld: begin
                if (fall) begin
                    state_d = StIdle;
                end else if (rep_hit) begin
                    cnt_d = '0;
                end else if (i_tick && (REPEAT_TICKS != 0)) begin
                    cnt_d = cnt_inc[CntW-1:0];
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Event posted this cycle, if any.
    always_comb begin
        post      = 1'b0;
        post_type = EvtPress;
        unique case (state_q)
            StIdle: begin
                if (rise) begin
                    post      = 1'b1;
                    post_type = EvtPress;
                end
            end
            StWaitLong: begin
                if (fall) begin
                    post      = 1'b1;
                    post_type = EvtRelease;
                end else if (long_hit) begin
                    post      = 1'b1;
                    post_type = EvtLong;
                end
            end
            StHeld: begin
                if (fall) begin
                    post      = 1'b1;
                    post_type = EvtRelease;
                end else if (rep_hit) begin
                    post      = 1'b1;
                    post_type = EvtRepeat;
                end
            end
            default: post = 1'b0;
        endcase
    end

    // Pending slot: a slot being granted this cycle can take a new event without a drop.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            pend_valid_q <= 1'b0;
            pend_type_q  <= EvtPress;
            drop_q       <= 1'b0;
        end else if (post && pend_valid_q && !i_grant) begin
            drop_q <= 1'b1;
        end else if (post) begin
            pend_valid_q <= 1'b1;
            pend_type_q  <= post_type;
        end else if (i_grant) begin
            pend_valid_q <= 1'b0;
        end
    end

    assign o_pend_valid = pend_valid_q;
    assign o_pend_type  = pend_type_q;
    assign o_drop       = drop_q;

endmodule

// File: rtl/btn_event_ctrl.sv
// Merges per-button key events into one valid/ready stream via a round-robin arbiter.
module btn_event_ctrl
    import hdmi_btn_pkg::*;
#(
    parameter int unsigned N_BTN        = 4,
    parameter int unsigned TICK_DIV     = 25_000,
    parameter int unsigned LONG_TICKS   = 500,
    parameter int unsigned REPEAT_TICKS = 100,
    localparam int unsigned BTN_W       = (N_BTN > 1) ? $clog2(N_BTN) : 1
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic [N_BTN-1:0] i_btn,
    output logic             o_evt_valid,
    input  logic             i_evt_ready,
    output logic [BTN_W-1:0] o_evt_btn,
    output logic [1:0]       o_evt_type,
    output logic [N_BTN-1:0] o_drop
);
    localparam int unsigned DivW = $clog2(TICK_DIV);

    logic [DivW-1:0]  presc_q;
    logic             tick;
    logic [N_BTN-1:0] pend_valid;
    logic [1:0]       pend_type [N_BTN];
    logic [N_BTN-1:0] grant_vec;
    logic             grant_any;
    logic [BTN_W-1:0] grant_idx;
    logic             out_free;
    int unsigned      arb_idx;
    logic [BTN_W-1:0] rr_q;
    logic [BTN_W-1:0] rr_d;
    logic             evt_valid_q;
    logic [BTN_W-1:0] evt_btn_q;
    logic [1:0]       evt_type_q;

    assign tick = (presc_q == DivW'(TICK_DIV - 1));

    // Free-running prescaler shared by every button.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            presc_q <= '0;
        end else if (tick) begin
            presc_q <= '0;
        end else begin
            presc_q <= presc_q + DivW'(1);
        end
    end

    for (genvar b = 0; b < N_BTN; b++) begin : g_btn
        btn_evt_fsm #(
            .LONG_TICKS   (LONG_TICKS),
            .REPEAT_TICKS (REPEAT_TICKS)
        ) u_fsm (
            .i_clk        (i_clk),
            .i_rst        (i_rst),
            .i_btn        (i_btn[b]),
            .i_tick       (tick),
            .i_grant      (grant_vec[b]),
            .o_pend_valid (pend_valid[b]),
            .o_pend_type  (pend_type[b]),
            .o_drop       (o_drop[b])
        );
    end

    // Round-robin pick of the first pending slot at or after rr_q.
    always_comb begin
        grant_any = 1'b0;
        grant_idx = '0;
        grant_vec = '0;
        arb_idx   = 0;
        out_free  = ~evt_valid_q | i_evt_ready;
        for (int unsigned i = 0; i < N_BTN; i++) begin
            arb_idx = (32'(rr_q) + i) % N_BTN;
            if (out_free && !grant_any && pend_valid[arb_idx]) begin
                grant_any = 1'b1;
                grant_idx = BTN_W'(arb_idx);
            end
        end
        if (grant_any) begin
            grant_vec[grant_idx] = 1'b1;
        end
        rr_d = (32'(grant_idx) == N_BTN - 1) ? '0 : grant_idx + BTN_W'(1);
    end

    // Output register holds an event stable until the consumer takes it.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            evt_valid_q <= 1'b0;
            evt_btn_q   <= '0;
            evt_type_q  <= EvtPress;
            rr_q        <= '0;
        end else if (grant_any) begin
            evt_valid_q <= 1'b1;
            evt_btn_q   <= grant_idx;
            evt_type_q  <= pend_type[grant_idx];
            rr_q        <= rr_d;
        end else if (i_evt_ready) begin
            evt_valid_q <= 1'b0;
        end
    end

    assign o_evt_valid = evt_valid_q;
    assign o_evt_btn   = evt_btn_q;
    assign o_evt_type  = evt_type_q;

endmodule

// File: tb/tb_btn_event_ctrl.sv
// Randomised and directed bench for btn_event_ctrl against a cycle-level behavioural model.
module tb_btn_event_ctrl;
    localparam int N  = 4;
    localparam int TD = 4;
    localparam int LT = 3;
    localparam int RT = 2;
    localparam logic [1:0] PRESS   = 2'd0;
    localparam logic [1:0] LONG    = 2'd1;
    localparam logic [1:0] REPEAT  = 2'd2;
    localparam logic [1:0] RELEASE = 2'd3;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] btn = 4'b0;
    logic       ready = 1'b0;
    logic       evt_valid;
    logic [1:0] evt_btn;
    logic [1:0] evt_type;
    logic [3:0] drop;

    int checks = 0;
    int errors = 0;

    // Behavioural model: ticks since press, one pending slot per button, output register.
    int         m_presc = 0;
    bit         m_prev   [N];
    bit         m_active [N];
    int         m_ticks  [N];
    bit         m_pend   [N];
    logic [1:0] m_ptype  [N];
    logic [3:0] m_drop  = 4'b0;
    bit         m_valid = 1'b0;
    logic [1:0] m_btn   = 2'd0;
    logic [1:0] m_type  = 2'd0;
    int         m_rr    = 0;

    btn_event_ctrl #(
        .N_BTN        (N),
        .TICK_DIV     (TD),
        .LONG_TICKS   (LT),
        .REPEAT_TICKS (RT)
    ) dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_btn       (btn),
        .o_evt_valid (evt_valid),
        .i_evt_ready (ready),
        .o_evt_btn   (evt_btn),
        .o_evt_type  (evt_type),
        .o_drop      (drop)
    );

    always #5 clk = ~clk;

    task automatic model_step();
        bit         tick;
        int         g;
        bit         post;
        logic [1:0] ev;
        if (rst) begin
            m_presc = 0; m_valid = 0; m_btn = 0; m_type = 0; m_rr = 0; m_drop = 0;
            for (int b = 0; b < N; b++) begin
                m_prev[b] = 0; m_active[b] = 0; m_ticks[b] = 0; m_pend[b] = 0; m_ptype[b] = 0;
            end
        end else begin
            tick    = (m_presc == TD - 1);
            m_presc = (m_presc + 1) % TD;
            g = -1;
            if (!m_valid || ready) begin
                for (int i = 0; i < N; i++) begin
                    if (g < 0 && m_pend[(m_rr + i) % N]) g = (m_rr + i) % N;
                end
            end
            if (g >= 0) begin
                m_valid = 1; m_btn = 2'(g); m_type = m_ptype[g]; m_rr = (g + 1) % N;
            end else if (ready) begin
                m_valid = 0;
            end
            for (int b = 0; b < N; b++) begin
                post = 0;
                ev   = PRESS;
                if (!m_active[b]) begin
                    if (btn[b] && !m_prev[b]) begin
                        post = 1; ev = PRESS; m_active[b] = 1; m_ticks[b] = 0;
                    end
                end else if (!btn[b]) begin
                    post = 1; ev = RELEASE; m_active[b] = 0;
                end else if (tick) begin
                    m_ticks[b]++;
                    if (m_ticks[b] == LT) begin
                        post = 1; ev = LONG;
                    end else if (m_ticks[b] > LT && ((m_ticks[b] - LT) % RT) == 0) begin
                        post = 1; ev = REPEAT;
                    end
                end
                if (post) begin
                    if (m_pend[b] && g != b) m_drop[b] = 1'b1;
                    else begin
                        m_pend[b] = 1; m_ptype[b] = ev;
                    end
                end else if (g == b) begin
                    m_pend[b] = 0;
                end
                m_prev[b] = btn[b];
            end
        end
    endtask

    always @(posedge clk) model_step();

    // Every cycle the DUT must match the model.
    always @(negedge clk) begin
        checks++;
        if (evt_valid !== m_valid || drop !== m_drop ||
            (m_valid && (evt_btn !== m_btn || evt_type !== m_type))) begin
            errors++;
            $display("FAIL model t=%0t valid %b want %b btn %0d want %0d type %0d want %0d drop %b want %b",
                     $time, evt_valid, m_valid, evt_btn, m_btn, evt_type, m_type, drop, m_drop);
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1; btn = 0; ready = 1;
        repeat (3) cyc();
        checks++;
        if ({evt_valid, evt_btn, evt_type, drop} !== 9'b0) begin
            errors++;
            $display("FAIL reset_outputs got %b want 0", {evt_valid, evt_btn, evt_type, drop});
        end
        rst = 0;
    endtask

    task automatic test_tap();
        bit seen_rel = 0;
        bit seen_long = 0;
        ready = 1;
        for (int c = 0; c < 14; c++) begin
            btn = (c < 5) ? 4'b0010 : 4'b0000;
            cyc();
            if (c == 0) begin
                checks++;
                if (evt_valid !== 1'b0) begin
                    errors++; $display("FAIL tap_early valid %b want 0", evt_valid);
                end
            end
            if (c == 1) begin
                checks++;
                if (evt_valid !== 1'b1 || evt_btn !== 2'd1 || evt_type !== PRESS) begin
                    errors++;
                    $display("FAIL tap_press got v%b b%0d t%0d want v1 b1 t0", evt_valid, evt_btn, evt_type);
                end
            end
            if (evt_valid && evt_type === RELEASE && evt_btn === 2'd1) seen_rel = 1;
            if (evt_valid && evt_type === LONG) seen_long = 1;
        end
        checks++;
        if (seen_rel !== 1'b1 || seen_long !== 1'b0 || drop !== 4'b0) begin
            errors++;
            $display("FAIL tap_release rel %b long %b drop %b want 1 0 0000", seen_rel, seen_long, drop);
        end
    endtask

    task automatic test_hold();
        int n[4] = '{0, 0, 0, 0};
        ready = 1;
        for (int c = 0; c < 52; c++) begin
            btn = (c < 40) ? 4'b0001 : 4'b0000;
            cyc();
            if (evt_valid && evt_btn === 2'd0) n[evt_type]++;
        end
        checks++;
        if (n[0] != 1 || n[1] != 1 || n[2] != 3 || n[3] != 1) begin
            errors++;
            $display("FAIL hold_counts press %0d long %0d repeat %0d release %0d want 1 1 3 1",
                     n[0], n[1], n[2], n[3]);
        end
    endtask

    task automatic test_simultaneous();
        logic [1:0] order_a [4] = '{2'd0, 2'd1, 2'd2, 2'd3};
        logic [1:0] order_b [4] = '{2'd2, 2'd3, 2'd0, 2'd1};
        ready = 1;
        // Tap btn3 so the pointer wraps back to 0.
        for (int c = 0; c < 10; c++) begin btn = (c < 3) ? 4'b1000 : 4'b0000; cyc(); end
        for (int c = 0; c < 18; c++) begin
            btn = (c < 8) ? 4'b1111 : 4'b0000;
            cyc();
            if (c >= 1 && c <= 4) begin
                checks++;
                if (evt_valid !== 1'b1 || evt_btn !== order_a[c-1] || evt_type !== PRESS) begin
                    errors++;
                    $display("FAIL simul_a[%0d] got v%b b%0d t%0d want b%0d press", c - 1,
                             evt_valid, evt_btn, evt_type, order_a[c-1]);
                end
            end
        end
        // Tap btn1 so the pointer lands on 2.
        for (int c = 0; c < 10; c++) begin btn = (c < 3) ? 4'b0010 : 4'b0000; cyc(); end
        for (int c = 0; c < 18; c++) begin
            btn = (c < 8) ? 4'b1111 : 4'b0000;
            cyc();
            if (c >= 1 && c <= 4) begin
                checks++;
                if (evt_valid !== 1'b1 || evt_btn !== order_b[c-1] || evt_type !== PRESS) begin
                    errors++;
                    $display("FAIL simul_b[%0d] got v%b b%0d t%0d want b%0d press", c - 1,
                             evt_valid, evt_btn, evt_type, order_b[c-1]);
                end
            end
        end
    endtask

    task automatic test_drop();
        logic [3:0] pat [8] = '{4'b0100, 4'b0100, 4'b0, 4'b0, 4'b0100, 4'b0100, 4'b0, 4'b0};
        ready = 0;
        for (int c = 0; c < 8; c++) begin btn = pat[c]; cyc(); end
        checks++;
        if (evt_valid !== 1'b1 || evt_btn !== 2'd2 || evt_type !== PRESS || drop !== 4'b0100) begin
            errors++;
            $display("FAIL drop_hold got v%b b%0d t%0d drop %b want v1 b2 t0 0100",
                     evt_valid, evt_btn, evt_type, drop);
        end
        ready = 1;
        for (int c = 0; c < 10; c++) begin btn = 4'b0; cyc(); end
        checks++;
        if (drop !== 4'b0100 || evt_valid !== 1'b0) begin
            errors++;
            $display("FAIL drop_sticky drop %b valid %b want 0100 0", drop, evt_valid);
        end
    endtask

    task automatic test_fall_vs_long();
        bit found = 0;
        bit seen_long = 0;
        bit seen_rel = 0;
        ready = 1;
        btn = 4'b0001;
        for (int c = 0; c < 60 && !found; c++) begin
            cyc();
            if (evt_valid && evt_type === LONG) seen_long = 1;
            // Release exactly in the cycle whose tick would complete the long-press count.
            if (m_active[0] && m_ticks[0] == LT - 1 && m_presc == TD - 1) begin
                btn = 4'b0;
                found = 1;
            end
        end
        btn = 4'b0;
        for (int c = 0; c < 8; c++) begin
            cyc();
            if (evt_valid && evt_type === LONG) seen_long = 1;
            if (evt_valid && evt_type === RELEASE && evt_btn === 2'd0) seen_rel = 1;
        end
        checks++;
        if (found !== 1'b1 || seen_long !== 1'b0 || seen_rel !== 1'b1) begin
            errors++;
            $display("FAIL fall_vs_long found %b long %b release %b want 1 0 1", found, seen_long, seen_rel);
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 800; c++) begin
            for (int b = 0; b < N; b++) begin
                if ($urandom_range(0, 11) == 0) btn[b] = ~btn[b];
            end
            ready = ($urandom_range(0, 3) != 0);
            cyc();
        end
        btn = 4'b0;
        ready = 1;
        repeat (12) cyc();
    endtask

    task automatic test_reset_mid();
        bit got = 0;
        ready = 0;
        btn = 4'b1000;
        for (int c = 0; c < 10 && !got; c++) begin
            cyc();
            if (evt_valid) got = 1;
        end
        checks++;
        if (!got) begin
            errors++; $display("FAIL rstmid_wait valid %b want 1 within 10 cycles", evt_valid);
        end
        rst = 1;
        cyc();
        checks++;
        if ({evt_valid, evt_btn, evt_type, drop} !== 9'b0) begin
            errors++;
            $display("FAIL rstmid_outputs got %b want 0", {evt_valid, evt_btn, evt_type, drop});
        end
        rst = 0;
        cyc();
        checks++;
        if (evt_valid !== 1'b0) begin
            errors++; $display("FAIL rstmid_first valid %b want 0", evt_valid);
        end
        cyc();
        checks++;
        if (evt_valid !== 1'b1 || evt_btn !== 2'd3 || evt_type !== PRESS) begin
            errors++;
            $display("FAIL rstmid_press got v%b b%0d t%0d want v1 b3 t0", evt_valid, evt_btn, evt_type);
        end
        btn = 4'b0;
        ready = 1;
        repeat (6) cyc();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_tap();
        test_hold();
        test_simultaneous();
        test_drop();
        test_fall_vs_long();
        test_random();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/btn_event_ctrl.md
# btn_event_ctrl

Turns N debounced front-panel buttons into a single stream of typed key events (press, long-press, auto-repeat, release) for the HDMI mode/pattern selection logic. Sits directly downstream of the per-button debounce instances and upstream of the configuration register block. Buttons are shared onto one output port by a round-robin arbiter with a valid/ready handshake.

## Interface
- N_BTN, 4, number of buttons (1..16)
- TICK_DIV, 25_000, clocks per time tick (1 ms at 25 MHz); ≥2
- LONG_TICKS, 500, ticks held before LONG event; ≥1
- REPEAT_TICKS, 100, ticks between REPEAT events after LONG; 0 disables repeat
- i_clk  in  1  system clock
- i_rst  in  1  synchronous reset, active-high
- i_btn  in  N_BTN  debounced button levels, 1 = pressed, already synchronous to i_clk
- o_evt_valid  out  1  event available
- i_evt_ready  in  1  consumer accepts event when o_evt_valid & i_evt_ready
- o_evt_btn  out  max(1,$clog2(N_BTN))  button index of event
- o_evt_type  out  2  0 PRESS, 1 LONG, 2 REPEAT, 3 RELEASE
- o_drop  out  N_BTN  sticky per-button flag: an event was discarded

## Operation
- Tick prescaler: free-running 0..TICK_DIV-1; one-cycle tick pulse on wrap; shared by all buttons.
- i_btn registered once (r_btn) for edge detection; rise = i_btn & ~r_btn, fall = ~i_btn & r_btn.
- Per-button FSM, states IDLE, WAIT_LONG, HELD:
  - IDLE: rise -> post PRESS, clear tick counter, go WAIT_LONG.
  - WAIT_LONG: count ticks; count reaching LONG_TICKS -> post LONG, clear counter, go HELD; fall -> post RELEASE, go IDLE.
  - HELD: if REPEAT_TICKS≠0, count reaching REPEAT_TICKS -> post REPEAT, clear counter; fall -> post RELEASE, go IDLE.
  - Fall takes priority over a same-cycle tick expiry (RELEASE only).
- Tick counter width $clog2(max(LONG_TICKS,REPEAT_TICKS)+1); first-tick quantisation up to one tick is accepted.
- Each button has one pending slot (valid + type). Posting into an occupied slot discards the new event and sets o_drop[b]; exception: if the slot is granted in the same cycle, the new event is stored, no drop.
- Arbiter: when output register empty or being accepted (~o_evt_valid | i_evt_ready) and any slot pending, grant the first pending button at or after rr_ptr (wrapping); load o_evt_btn/o_evt_type, clear that slot, rr_ptr <= granted+1 (wraps to 0 after N_BTN-1).
- o_evt_valid stays high with stable btn/type until accepted.

## Timing
- Reset: o_evt_valid=0, o_evt_btn=0, o_evt_type=0, o_drop=0, all FSMs IDLE, slots empty, rr_ptr=0, prescaler=0, r_btn=0 (a button held through reset yields PRESS on the first cycle after reset).
- Latency: edge on i_btn at cycle k -> slot set at k+1 -> o_evt_valid at k+2 if output free.
- Throughput: one event per cycle with i_evt_ready tied high.
- Reset mid-operation discards pending and output events without handshake.

## Structure
- Package hdmi_btn_pkg: evt_type_t enum (PRESS/LONG/REPEAT/RELEASE encodings), FSM state enum.
- Sub-module btn_evt_fsm: one per button (edge detect, tick counter, FSM, pending slot); top holds prescaler, arbiter, output register.

## Test plan
Use N_BTN=4, TICK_DIV=4, LONG_TICKS=3, REPEAT_TICKS=2.
- Tap btn1 for 5 cycles, ready=1 -> PRESS(1) at edge+2, then RELEASE(1); no LONG; o_drop=0.
- Hold btn0 for 40 cycles -> PRESS, LONG after 3 ticks (~12 cycles), REPEAT every 8 cycles, RELEASE on fall.
- Press btn0..btn3 in same cycle, ready=1 -> PRESS 0,1,2,3 on consecutive cycles; repeat with rr_ptr=2 -> order 2,3,0,1.
- ready=0 while btn2 taps twice -> output holds PRESS(2); second PRESS dropped, o_drop[2]=1 sticky until i_rst.
- Fall coincident with LONG expiry -> only RELEASE emitted; i_rst asserted with o_evt_valid=1 -> o_evt_valid=0 next cycle, all outputs at reset values.
